// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, permutation helpers and FSM state type.
// Table entries use DES numbering: bit 1 is the MSB of the source word.
package des_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Row-major: entry index = row * 16 + column.
  localparam int SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Right rotation of C and D before decrypt round r+1 (the encrypt shifts replayed backwards).
  localparam int RSHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] s_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      y[5'(31 - 4 * b) -: 4] = 4'(SBOX_T[3'(b)][{six[5], six[0], six[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [55:0] cd_step(input logic [55:0] cd, input logic [3:0] round);
    logic [1:0] n;
    n = 2'(RSHIFT_T[round]);
    return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
  endfunction

endpackage

// File: rtl/des_round.sv
// rtl/des_round.sv - one combinational DES Feistel round, shared by encrypt and decrypt.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);

  assign l_out = r_in;
  assign r_out = l_in ^ p_perm(s_sub(e_exp(r_in) ^ subkey));

endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryption, ROUNDS_PER_CYCLE rounds per clock.
// Subkeys come from right-rotating PC1(key), so no subkey table is stored.
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int RPC = ROUNDS_PER_CYCLE;

  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
    $error("des_decrypt_core: ROUNDS_PER_CYCLE=%0d, must be 1, 2, 4, 8 or 16", RPC);
  end

  state_e      state_q, state_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [55:0] cd_q, cd_d;
  logic [63:0] out_data_q, out_data_d;
  logic [63:0] ip_block;
  logic        accept;
  logic        last_round;

  logic [31:0] l_s  [RPC+1];
  logic [31:0] r_s  [RPC+1];
  logic [55:0] cd_s [RPC+1];

  assign accept     = in_valid && (state_q == S_IDLE);
  assign last_round = (5'(round_cnt_q) + 5'(RPC)) == 5'd16;

  assign l_s[0]  = l_q;
  assign r_s[0]  = r_q;
  assign cd_s[0] = cd_q;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    assign cd_s[j+1] = cd_step(cd_s[j], round_cnt_q + 4'(j));
    des_round u_round (
      .l_in   (l_s[j]),
      .r_in   (r_s[j]),
      .subkey (pc2(cd_s[j+1])),
      .l_out  (l_s[j+1]),
      .r_out  (r_s[j+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_ROUND;
      S_ROUND: if (last_round) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    l_d         = l_q;
    r_d         = r_q;
    cd_d        = cd_q;
    round_cnt_d = round_cnt_q;
    out_data_d  = out_data_q;
    ip_block    = ip(in_data);
    if (accept) begin
      l_d         = ip_block[63:32];
      r_d         = ip_block[31:0];
      cd_d        = pc1(in_key);
      round_cnt_d = '0;
    end else if (state_q == S_ROUND) begin
      l_d         = l_s[RPC];
      r_d         = r_s[RPC];
      cd_d        = cd_s[RPC];
      round_cnt_d = round_cnt_q + 4'(RPC);
      // Output swap R16 || L16 undoes the swap of the last round.
      if (last_round) out_data_d = fp({r_s[RPC], l_s[RPC]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      round_cnt_q <= '0;
      out_data_q  <= '0;
    end else begin
      l_q         <= l_d;
      r_q         <= r_d;
      cd_q        <= cd_d;
      round_cnt_q <= round_cnt_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - self-checking bench for des_decrypt_core.
`timescale 1ns/1ps
module tb_des_decrypt_core;

  localparam int LSH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [63:0] in_data   [4];
  logic [63:0] in_key    [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [63:0] out_data  [4];
  logic        busy      [4];

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RPC = (g == 3) ? 16 : (1 << g);
    des_decrypt_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic int rpc_of(input int u);
    return (u == 3) ? 16 : (1 << u);
  endfunction

  function automatic int tab(input int id, input int i);
    case (id)
      0: return des_pkg::IP_T[i];
      1: return des_pkg::FP_T[i];
      2: return des_pkg::E_T[i];
      3: return des_pkg::P_T[i];
      4: return des_pkg::PC1_T[i];
      5: return des_pkg::PC2_T[i];
      default: return 1;
    endcase
  endfunction

  // Picks n bits out of the low src_w bits of src, MSB-first DES numbering.
  function automatic logic [63:0] perm(input logic [63:0] src, input int src_w, input int id,
                                       input int n);
    logic [63:0] y = 0;
    for (int i = 0; i < n; i++) y = (y << 1) | ((src >> (src_w - tab(id, i))) & 64'd1);
    return y;
  endfunction

  // Textbook DES: forward key schedule, subkeys consumed in reverse for decryption.
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key,
                                          input bit dec);
    logic [63:0] sk [16];
    logic [63:0] t, e, f;
    logic [27:0] c, d;
    logic [31:0] l, r, s, nl;
    int six, row, col;
    t = perm(key, 64, 4, 56);
    c = t[55:28];
    d = t[27:0];
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < LSH[k]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sk[k] = perm({8'h00, c, d}, 56, 5, 48);
    end
    t = perm(blk, 64, 0, 64);
    l = t[63:32];
    r = t[31:0];
    for (int k = 0; k < 16; k++) begin
      e = perm({32'h0, r}, 32, 2, 48) ^ (dec ? sk[15 - k] : sk[k]);
      s = 0;
      for (int b = 0; b < 8; b++) begin
        six = int'((e >> (42 - 6 * b)) & 64'h3F);
        row = ((six >> 4) & 2) | (six & 1);
        col = (six >> 1) & 15;
        s = (s << 4) | 32'(des_pkg::SBOX_T[b][row * 16 + col]);
      end
      f = perm({32'h0, s}, 32, 3, 32);
      nl = r;
      r = l ^ f[31:0];
      l = nl;
    end
    return perm({r, l}, 64, 1, 64);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input int u, input logic [63:0] data, input logic [63:0] key);
    int n = 0;
    while (!in_ready[u] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_seen", 64'(in_ready[u]), 64'd1);
    in_data[u]  = data;
    in_key[u]   = key;
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  // Counts the accept edge as clock 1.
  task automatic wait_valid(input int u, output int lat);
    lat = 1;
    while (!out_valid[u] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_seen", 64'(out_valid[u]), 64'd1);
  endtask

  task automatic take_output(input int u, input int stall, output logic [63:0] res);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res = out_data[u];
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
  endtask

  task automatic run_block(input int u, input logic [63:0] data, input logic [63:0] key,
                           input int stall, output logic [63:0] res, output int lat);
    start_block(u, data, key);
    wait_valid(u, lat);
    take_output(u, stall, res);
  endtask

  initial begin
    logic [63:0] res, hold, pt, key, ct, key2;
    int lat;
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      in_valid[u] = 1'b0;
      in_data[u] = '0;
      in_key[u] = '0;
      out_ready[u] = 1'b0;
    end
    #2;
    for (int u = 0; u < 4; u++) begin
      check("rst_in_ready", 64'(in_ready[u]), 64'd1);
      check("rst_out_valid", 64'(out_valid[u]), 64'd0);
      check("rst_out_data", out_data[u], 64'd0);
      check("rst_busy", 64'(busy[u]), 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check("ref_encrypt_kat", des_ref(PT1, KEY1, 1'b0), CT1);
    run_block(0, CT1, KEY1, 0, res, lat);
    check("kat1_data", res, PT1);
    check("kat1_latency", 64'(lat), 64'd17);

    // Asynchronous reset in the middle of a block.
    start_block(0, CT1, KEY1);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_out_data", out_data[0], 64'd0);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_block(0, CT1, KEY1, 0, res, lat);
    check("after_rst_data", res, PT1);
    check("after_rst_latency", 64'(lat), 64'd17);

    for (int u = 0; u < 4; u++) begin
      run_block(u, CT0, 64'h0, 0, res, lat);
      check("zero_key_data", res, 64'h0);
      check("zero_key_latency", 64'(lat), 64'(16 / rpc_of(u) + 1));
    end

    // Backpressure: a second request waits behind a stalled result.
    start_block(0, CT1, KEY1);
    wait_valid(0, lat);
    hold = out_data[0];
    check("bp_first_data", hold, PT1);
    in_data[0]  = CT0;
    in_key[0]   = 64'h0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_data_stable", out_data[0], hold);
      check("bp_valid_held", 64'(out_valid[0]), 64'd1);
      check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_consumed_valid", 64'(out_valid[0]), 64'd0);
    check("bp_not_yet_busy", 64'(busy[0]), 64'd0);
    check("bp_idle_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_accepted_busy", 64'(busy[0]), 64'd1);
    check("bp_accepted_ready", 64'(in_ready[0]), 64'd0);
    wait_valid(0, lat);
    check("bp_second_latency", 64'(lat), 64'd17);
    take_output(0, 0, res);
    check("bp_second_data", res, 64'h0);

    for (int i = 0; i < 1000; i++) begin
      pt  = {$urandom(), $urandom()};
      key = {$urandom(), $urandom()};
      ct  = des_ref(pt, key, 1'b0);
      run_block(0, ct, key, int'($urandom_range(0, 2)), res, lat);
      check("round_trip", res, pt);
      if (i % 8 == 0) begin
        key2 = key ^ ({$urandom(), $urandom()} & 64'h0101010101010101);
        run_block(0, ct, key2, 0, res, lat);
        check("parity_only_key", res, pt);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
